// File: rtl/sm3_arb_pkg.sv
// Shared types and widths for the SM3 message arbiter.
// The message word width follows the SM3 core build option.
package sm3_arb_pkg;

    typedef enum logic [1:0] {IDLE, XFER, WAIT_RES} sm3_arb_st_e;

    localparam int SM3_RES_W = 256;

`ifdef SM3_INPT_DW_64
    localparam int SM3_DW = 64;
`else
    localparam int SM3_DW = 32;
`endif

endpackage

// File: rtl/sm3_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping.
// Combinational; no state, no backpressure.
module sm3_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;

    // Two copies of the request vector; masking the low copy below ptr makes
    // a plain lowest-bit priority encoder honour the wrap-around order.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int j = 0; j < 2*N; j++) begin
            masked[j] = dbl[j] && (j >= int'(ptr));
        end
    end

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int j = 0; j < 2*N; j++) begin
            if (!any && masked[j]) begin
                any = 1'b1;
                idx = IW'((j >= N) ? (j - N) : j);
            end
        end
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/sm3_msg_arb.sv
// Shares one SM3 core among N requesters, one whole message per grant, hash routed back.
// Grant 1 clk after vld; data path is combinational; result 1 clk after the core pulse.
module sm3_msg_arb
    import sm3_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = SM3_DW,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_vld_i,
    input  logic [N*DW-1:0]      req_d_i,
    input  logic [N*DW/8-1:0]    req_vld_byte_i,
    input  logic [N-1:0]         req_lst_i,
    output logic [N-1:0]         req_rdy_o,
    output logic                 msg_inpt_vld_o,
    output logic [DW-1:0]        msg_inpt_d_o,
    output logic [DW/8-1:0]      msg_inpt_vld_byte_o,
    output logic                 msg_inpt_lst_o,
    input  logic                 msg_inpt_rdy_i,
    input  logic                 cmprss_otpt_vld_i,
    input  logic [SM3_RES_W-1:0] cmprss_otpt_res_i,
    output logic [N-1:0]         res_vld_o,
    output logic [SM3_RES_W-1:0] res_o,
    output logic [IW-1:0]        owner_o,
    output logic                 busy_o,
    output logic                 err_o
);

    sm3_arb_st_e   state;
    logic [IW-1:0] rr_ptr;
    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

    sm3_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req (req_vld_i),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        msg_inpt_vld_o      = 1'b0;
        msg_inpt_d_o        = '0;
        msg_inpt_vld_byte_o = '0;
        msg_inpt_lst_o      = 1'b0;
        req_rdy_o           = '0;
        if (state == XFER) begin
            for (int k = 0; k < N; k++) begin
                if (owner_o == IW'(k)) begin
                    msg_inpt_vld_o      = req_vld_i[k];
                    msg_inpt_d_o        = req_d_i[k*DW +: DW];
                    msg_inpt_vld_byte_o = req_vld_byte_i[k*(DW/8) +: DW/8];
                    msg_inpt_lst_o      = req_lst_i[k];
                    req_rdy_o[k]        = msg_inpt_rdy_i;
                end
            end
        end
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner_o   <= '0;
            res_vld_o <= '0;
            res_o     <= '0;
            err_o     <= 1'b0;
        end else begin
            res_vld_o <= '0;
            // A hash pulse outside WAIT_RES has no owner; flag it and drop it.
            if (cmprss_otpt_vld_i && (state != WAIT_RES)) begin
                err_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner_o <= pick_idx;
                        state   <= XFER;
                    end
                end
                XFER: begin
                    if (msg_inpt_vld_o && msg_inpt_rdy_i && msg_inpt_lst_o) begin
                        state <= WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (cmprss_otpt_vld_i) begin
                        res_o     <= cmprss_otpt_res_i;
                        res_vld_o <= N'(1) << owner_o;
                        rr_ptr    <= (owner_o == IW'(N - 1)) ? '0 : owner_o + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
